rx_page_reader: RTL

//  Read side of the receiver's ping-pong IQ sample memory. Waits for the writer to finish a page,

---
 rtl/rx_page_reader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rx_page_reader.sv
// rx_page_reader: read side of the ping-pong IQ sample memory.
// When the writer finishes a page, this block streams that page to the host
// as one byte frame: SYNC, seq, {ovf,7'b0}, then WORDS x 6 bytes, MSB first.
module rx_page_reader #(
  parameter int         WORDS = 82,
  parameter logic [7:0] SYNC  = 8'h7F
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mem_block,
  output logic        rd_en,
  output logic [7:0]  rd_addr,
  input  logic [47:0] rd_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic [15:0] overrun_cnt,
  output logic        busy
);

  localparam logic [6:0] LAST_W = 7'(WORDS - 1);
  localparam logic [7:0] NWORDS = 8'(WORDS);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t      state, state_nx;
  logic        mb_d, evt, ovr;
  logic        pending, pend_page, cur_page, ovf_flag;
  logic [7:0]  seq;
  logic [1:0]  hcnt;      // header byte currently on out_data
  logic [2:0]  bcnt;      // byte of current word currently on out_data
  logic [6:0]  wcnt;      // word currently being shifted out
  logic [7:0]  rd_ptr;    // next word index to request from RAM
  logic        rd_vld;    // rd_data carries the word requested last cycle
  logic [47:0] nxt_word;  // prefetched word waiting to be shifted
  logic [47:0] shreg;     // remaining bytes of the word being shifted
  logic        fire, start, hdr_done, word_done, frame_done, issue;

  // Any change of the completed-page index is a page event.
  assign evt  = mem_block ^ mb_d;
  assign busy = (state != IDLE);
  // A new page while one is still in flight (or already queued) is an overrun.
  assign ovr  = evt & enable & (busy | pending);

  // Next-state and frame-boundary strobes.
  always_comb begin
    state_nx   = state;
    fire       = out_valid & out_ready;
    start      = 1'b0;
    hdr_done   = 1'b0;
    word_done  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (pending && enable) begin
        start    = 1'b1;
        state_nx = HDR;
      end
      HDR: if (fire && hcnt == 2'd2) begin
        hdr_done = 1'b1;
        state_nx = DATA;
      end
      DATA: if (fire && bcnt == 3'd5) begin
        word_done = 1'b1;
        if (wcnt == LAST_W) begin
          frame_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read word k+1 as soon as word k starts shifting; word 0 on frame start.
  assign issue = start |
                 ((hdr_done | (word_done & ~frame_done)) & (rd_ptr != NWORDS));

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Page event tracking, pending page, overrun accounting and frame sequence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mb_d        <= 1'b0;
      pending     <= 1'b0;
      pend_page   <= 1'b0;
      cur_page    <= 1'b0;
      ovf_flag    <= 1'b0;
      overrun_cnt <= 16'd0;
      seq         <= 8'd0;
    end else begin
      mb_d <= mem_block;
      // Newest event wins; a start consumes the queued page unless a new one lands.
      if (!enable) pending <= 1'b0;
      else if (evt) begin
        pending   <= 1'b1;
        pend_page <= mem_block;
      end else if (start) pending <= 1'b0;
      if (start) cur_page <= pend_page;
      // Set has priority so an overrun landing on byte 2 is not lost.
      if (ovr)           ovf_flag <= 1'b1;
      else if (hdr_done) ovf_flag <= 1'b0;
      if (ovr && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
      if (frame_done) seq <= seq + 8'd1;
    end
  end

  // RAM read port: one-cycle read strobes and capture of the returned word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_en    <= 1'b0;
      rd_addr  <= 8'd0;
      rd_ptr   <= 8'd0;
      rd_vld   <= 1'b0;
      nxt_word <= 48'd0;
    end else begin
      rd_en  <= issue;
      rd_vld <= rd_en;
      if (rd_vld) nxt_word <= rd_data;
      if (start) begin
        rd_addr <= {pend_page, 7'd0};
        rd_ptr  <= 8'd1;
      end else if (issue) begin
        rd_addr <= {cur_page, rd_ptr[6:0]};
        rd_ptr  <= rd_ptr + 8'd1;
      end
    end
  end

  // Byte stream: outputs only advance on an accepted byte, so they hold while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      hcnt      <= 2'd0;
      bcnt      <= 3'd0;
      wcnt      <= 7'd0;
      shreg     <= 48'd0;
    end else if (start) begin
      out_valid <= 1'b1;
      out_data  <= SYNC;
      out_sop   <= 1'b1;
      out_eop   <= 1'b0;
      hcnt      <= 2'd0;
    end else if (hdr_done) begin
      out_data <= nxt_word[47:40];
      shreg    <= {nxt_word[39:0], 8'h00};
      bcnt     <= 3'd0;
      wcnt     <= 7'd0;
    end else if (state == HDR && fire) begin
      out_sop  <= 1'b0;
      out_data <= (hcnt == 2'd0) ? seq : {ovf_flag, 7'd0};
      hcnt     <= hcnt + 2'd1;
    end else if (frame_done) begin
      out_valid <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= 8'd0;
    end else if (word_done) begin
      out_data <= nxt_word[47:40];
      shreg    <= {nxt_word[39:0], 8'h00};
      bcnt     <= 3'd0;
      wcnt     <= wcnt + 7'd1;
    end else if (state == DATA && fire) begin
      out_data <= shreg[47:40];
      shreg    <= {shreg[39:0], 8'h00};
      bcnt     <= bcnt + 3'd1;
      out_eop  <= (bcnt == 3'd4) && (wcnt == LAST_W);
    end
  end

endmodule
